// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_EARLY_OUT_EN to send divide-by-zero, signed overflow and zero-operand multiplies straight to FIX.
module mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mdCtrl,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int               CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div;
   logic             r_sel_hi;
   logic             r_sel_rem;
   logic             r_neg_res;
   logic             r_neg_a;
   logic             r_div0;
   logic             r_ovf;
   logic [WIDTH-1:0] r_a_raw;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_result;

   logic             w_accept;
   logic             w_is_div;
   logic             w_a_signed;
   logic             w_b_signed;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_div0;
   logic             w_ovf;
   logic             w_early;

   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic               w_fits;
   logic [WIDTH-1:0]   w_hi_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_fix_res;

   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // Operand decode happens on the raw inputs so the accept edge can latch magnitudes and sign flags.
   always_comb begin
      w_is_div   = mdCtrl[2];
      w_a_signed = (mdCtrl == OP_MULH) || (mdCtrl == OP_MULHSU) ||
                   (mdCtrl == OP_DIV)  || (mdCtrl == OP_REM);
      w_b_signed = (mdCtrl == OP_MULH) || (mdCtrl == OP_DIV) || (mdCtrl == OP_REM);
      w_a_neg    = w_a_signed && opA[WIDTH-1];
      w_b_neg    = w_b_signed && opB[WIDTH-1];
      w_a_mag    = w_a_neg ? -opA : opA;
      w_b_mag    = w_b_neg ? -opB : opB;
      w_div0     = w_is_div && (opB == '0);
      w_ovf      = w_is_div && w_a_signed && (opA == MOST_NEG) && (opB == '1);
`ifdef MDU_EARLY_OUT_EN
      w_early    = w_div0 || w_ovf || (!w_is_div && ((opA == '0) || (opB == '0)));
`else
      w_early    = 1'b0;
`endif
   end

   // r_hi/r_lo hold {product high, product low} for multiply and {remainder, quotient} for divide.
   always_comb begin
      w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_opnd};
      w_fits  = !w_diff[WIDTH];
      if (r_is_div) begin
         w_hi_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
         w_lo_nxt = {r_lo[WIDTH-2:0], w_fits};
      end else begin
         w_hi_nxt = w_add[WIDTH:1];
         w_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
      end
   end

   // NOTE: every path through this block assigns every output, so no latch can be inferred.
   always_comb begin
      w_prod = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
      w_quo  = r_neg_res ? -r_lo : r_lo;
      w_rem  = r_neg_a   ? -r_hi : r_hi;
      if (r_div0) begin
         w_quo = '1;
         w_rem = r_a_raw;
      end else if (r_ovf) begin
         w_quo = MOST_NEG;
         w_rem = '0;
      end
      if (r_is_div) begin
         w_fix_res = r_sel_rem ? w_rem : w_quo;
      end else begin
         w_fix_res = r_sel_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_sel_hi  <= 1'b0;
         r_sel_rem <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_a   <= 1'b0;
         r_div0    <= 1'b0;
         r_ovf     <= 1'b0;
         r_a_raw   <= '0;
         r_opnd    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            S_CALC: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST_ITER) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_result <= w_fix_res;
               r_state  <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // An accepted start overrides the DONE->IDLE transition for back-to-back issue.
         if (w_accept) begin
            r_is_div  <= w_is_div;
            r_sel_hi  <= (mdCtrl[1:0] != 2'b00);
            r_sel_rem <= mdCtrl[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_a   <= w_a_neg;
            r_div0    <= w_div0;
            r_ovf     <= w_ovf;
            r_a_raw   <= opA;
            r_cnt     <= '0;
            r_hi      <= '0;
            if (w_early) begin
               r_lo    <= '0;
               r_opnd  <= '0;
               r_state <= S_FIX;
            end else begin
               r_lo    <= w_is_div ? w_a_mag : w_b_mag;
               r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
               r_state <= S_CALC;
            end
         end
      end
   end

   assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed RV32M cases with literal results plus randomized operations
// compared every cycle against a latency/arithmetic reference model.
module tb_mdu_seq;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int FULL_LAT    = 34;
   localparam int SPECIAL_LAT = EARLY ? 2 : 34;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        start  = 1'b0;
   logic [2:0]  mdCtrl = 3'b000;
   logic [31:0] opA    = 32'h0;
   logic [31:0] opB    = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_pass  = 0;
   int n_total = 0;

   mdu_seq #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mdCtrl (mdCtrl),
      .opA    (opA),
      .opB    (opB),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   // Reference arithmetic straight from the RV32M definitions, using 64-bit products.
   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (op)
         MUL:    begin p = ua * ub; return p[31:0];  end
         MULH:   begin p = sa * sb; return p[63:32]; end
         MULHSU: begin p = sa * ub; return p[63:32]; end
         MULHU:  begin p = ua * ub; return p[63:32]; end
         DIV: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         DIVU: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            return a / b;
         end
         REM: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit special;
      if (op[2]) special = (b == 32'h0) ||
                           ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      else       special = (a == 32'h0) || (b == 32'h0);
      return (EARLY && special) ? 2 : 34;
   endfunction

   // Cycle model: m_left counts the busy cycles still to come; done pulses as it reaches zero.
   int          m_left    = 0;
   logic        m_done    = 1'b0;
   logic [31:0] m_result  = 32'h0;
   logic [31:0] m_pending = 32'h0;
   bit          chk_en    = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_left   = 0;
         m_done   = 1'b0;
         m_result = 32'h0;
         chk_en   = 1'b1;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done   = 1'b1;
               m_result = m_pending;
            end
         end else if (start) begin
            m_pending = ref_mdu(mdCtrl, opA, opB);
            m_left    = ref_lat(mdCtrl, opA, opB) - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
         check("done", {31'h0, done}, {31'h0, m_done});
         check("result", result, m_result);
      end
   end

   // Called on a negedge; returns on the negedge of the first cycle after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      mdCtrl = op;
      opA    = a;
      opB    = b;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int nbusy);
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 100) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat, nbusy;
      issue(op, a, b);
      wait_done(lat, nbusy);
      check(name, result, exp_res);
      check({name, " latency"}, lat, exp_lat);
      check({name, " busy cycles"}, nbusy, exp_lat - 1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, nbusy;
      bit          saw_done;
      logic [2:0]  op;
      logic [31:0] a, b;

      repeat (3) @(negedge clk);
      check("reset busy", {31'h0, busy}, 32'h0);
      check("reset done", {31'h0, done}, 32'h0);
      check("reset result", result, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      run_op("MUL 7*-3",        MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT);
      run_op("MULHU -1*-1",     MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
      run_op("MULH -1*-1",      MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, FULL_LAT);
      run_op("MULHSU -1*2",     MULHSU, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, FULL_LAT);
      run_op("DIV -7/2",        DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, FULL_LAT);
      run_op("REM -7/2",        REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, FULL_LAT);
      run_op("DIVU 100/7",      DIVU,   32'd100,        32'd7,         32'd14,        FULL_LAT);
      run_op("REMU 100/7",      REMU,   32'd100,        32'd7,         32'd2,         FULL_LAT);
      run_op("DIVU 5/0",        DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, SPECIAL_LAT);
      run_op("REM 5/0",         REM,    32'd5,          32'd0,         32'd5,         SPECIAL_LAT);
      run_op("DIV ovf",         DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
      run_op("REM ovf",         REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         SPECIAL_LAT);
      run_op("MUL x*0",         MUL,    32'h1234_5678,  32'h0,         32'h0,         SPECIAL_LAT);

      // Start held high with operands churning: only the DONE-cycle operands may be taken next.
      mdCtrl = MUL;
      opA    = 32'd3;
      opB    = 32'd5;
      start  = 1'b1;
      @(negedge clk);
      lat = 1;
      while (!done && lat < 100) begin
         opA    = $urandom;
         opB    = $urandom;
         mdCtrl = 3'($urandom_range(0, 7));
         @(negedge clk);
         lat++;
      end
      check("held MUL 3*5", result, 32'd15);
      check("held MUL latency", lat, FULL_LAT);
      mdCtrl = MUL;
      opA    = 32'd6;
      opB    = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, nbusy);
      check("back-to-back MUL 6*7", result, 32'd42);
      check("back-to-back spacing", lat, FULL_LAT);

      // Reset at cycle 10 of a divide discards it without a done pulse.
      issue(DIVU, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid-op reset busy", {31'h0, busy}, 32'h0);
      check("mid-op reset result", result, 32'h0);
      check("mid-op reset done", {31'h0, done}, 32'h0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("no done after reset", {31'h0, saw_done}, 32'h0);
      run_op("MUL 3*4 after reset", MUL, 32'd3, 32'd4, 32'd12, FULL_LAT);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         issue(op, a, b);
         wait_done(lat, nbusy);
         check("random result", result, ref_mdu(op, a, b));
         check("random latency", lat, ref_lat(op, a, b));
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
